// File: rtl/sdram_responder.sv
// Memory-side stand-in for the KNN core's single-word SDRAM port.
// Edge-triggered requests with fixed read latency and write occupancy; bit-offset addressing.
module sdram_responder #(
  parameter int unsigned W            = 16,
  parameter int unsigned ADDR_W       = 25,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned WRITE_CYCLES = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic [ADDR_W-1:0] readaddress,
  output logic [W-1:0]      readdata,
  output logic              readdatavalid,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeaddress,
  input  logic [W-1:0]      writedata,
  output logic              busy,
  output logic              dropped
);

  localparam int unsigned OFF    = $clog2(W);
  localparam int unsigned IDX_W  = ADDR_W - OFF;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MAXC   = (READ_LATENCY > WRITE_CYCLES) ? READ_LATENCY : WRITE_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAXC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [W-1:0] mem [DEPTH];

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             read_q, write_q;
  logic [IDX_W-1:0] raddr_q, raddr_n;
  logic [W-1:0]     readdata_n;
  logic             readdatavalid_n, busy_n, dropped_n;

  logic             rd_edge, wr_edge, accept, mem_we;
  logic [IDX_W-1:0] ridx, widx;
  logic             w_in_range, r_in_range;
  logic             unused_low_bits;

  // Sub-word address bits are truncated away.
  assign ridx    = readaddress[ADDR_W-1:OFF];
  assign widx    = writeaddress[ADDR_W-1:OFF];
  assign unused_low_bits = ^{readaddress[OFF-1:0], writeaddress[OFF-1:0]};

  assign rd_edge    = read & ~read_q;
  assign wr_edge    = write & ~write_q;
  assign w_in_range = 32'(widx) < 32'(DEPTH);
  assign r_in_range = 32'(raddr_q) < 32'(DEPTH);

  // Next-state logic; a wait state at cnt==0 can accept the next request on the same edge.
  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    raddr_n         = raddr_q;
    readdata_n      = readdata;
    readdatavalid_n = 1'b0;
    dropped_n       = 1'b0;
    accept          = 1'b0;
    mem_we          = 1'b0;
    case (state)
      S_IDLE: accept = 1'b1;
      S_READ: begin
        if (cnt == '0) begin
          readdata_n      = r_in_range ? mem[raddr_q[MEM_AW-1:0]] : '0;
          readdatavalid_n = 1'b1;
          state_n         = S_IDLE;
          accept          = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
          accept  = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (accept) begin
      if (wr_edge) begin
        mem_we    = w_in_range;
        cnt_n     = CNT_W'(WRITE_CYCLES - 1);
        state_n   = S_WRITE;
        dropped_n = rd_edge;
      end else if (rd_edge) begin
        raddr_n = ridx;
        cnt_n   = CNT_W'(READ_LATENCY - 1);
        state_n = S_READ;
      end
    end else begin
      dropped_n = rd_edge | wr_edge;
    end
    busy_n = (state_n != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      raddr_q       <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
      busy          <= 1'b0;
      dropped       <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      read_q        <= read;
      write_q       <= write;
      raddr_q       <= raddr_n;
      readdata      <= readdata_n;
      readdatavalid <= readdatavalid_n;
      busy          <= busy_n;
      dropped       <= dropped_n;
    end
  end

  // Storage survives reset; writes commit at acceptance.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[widx[MEM_AW-1:0]] <= writedata;
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: scoreboard of expected reads plus timing/occupancy checks,
// and a READ_LATENCY=1/WRITE_CYCLES=1 instance driven with alternating write/read edges.
module tb_sdram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        read, write;
  logic [24:0] readaddress, writeaddress;
  logic [15:0] writedata, readdata;
  logic        readdatavalid, busy, dropped;

  logic        f_read, f_write;
  logic [24:0] f_raddr, f_waddr;
  logic [15:0] f_wdata, f_rdata;
  logic        f_rdv, f_busy, f_dropped;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdv_cnt = 0;
  int drop_cnt = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sdram_responder dut (
    .clk(clk), .rst(rst),
    .read(read), .readaddress(readaddress), .readdata(readdata), .readdatavalid(readdatavalid),
    .write(write), .writeaddress(writeaddress), .writedata(writedata),
    .busy(busy), .dropped(dropped)
  );

  sdram_responder #(.READ_LATENCY(1), .WRITE_CYCLES(1)) fast (
    .clk(clk), .rst(rst),
    .read(f_read), .readaddress(f_raddr), .readdata(f_rdata), .readdatavalid(f_rdv),
    .write(f_write), .writeaddress(f_waddr), .writedata(f_wdata),
    .busy(f_busy), .dropped(f_dropped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: data and exact arrival cycle of every readdatavalid.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (dropped) drop_cnt++;
    if (readdatavalid) begin
      rdv_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_rdv", 32'(readdatavalid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rd_data", 32'(readdata), 32'(e.data));
        chk("rd_latency", 32'(cyc), 32'(e.due));
      end
    end else if (sb.size() > 0 && cyc >= sb[0].due) begin
      e = sb.pop_front();
      chk("rd_timeout", 32'(readdatavalid), 32'd1);
    end
  end

  // Called at a negedge; returns at the negedge before the earliest next acceptance.
  task automatic do_write(input logic [24:0] addr, input logic [15:0] data);
    write = 1'b1; writeaddress = addr; writedata = data;
    @(negedge clk);
    write = 1'b0;
    repeat (8) @(negedge clk);
    chk("wr_busy_last", 32'(busy), 32'd1);
  endtask

  task automatic do_read(input logic [24:0] addr, input logic [15:0] exp);
    exp_t e;
    read = 1'b1; readaddress = addr;
    e.data = exp; e.due = cyc + 1 + 3;
    sb.push_back(e);
    @(negedge clk);
    read = 1'b0;
    repeat (2) @(negedge clk);
    chk("rd_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    int d0, r0, bc;
    logic [15:0] fe [6];

    rst = 1'b1;
    read = 1'b0; write = 1'b0; readaddress = '0; writeaddress = '0; writedata = '0;
    f_read = 1'b0; f_write = 1'b0; f_raddr = '0; f_waddr = '0; f_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_readdata", 32'(readdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdv", 32'(readdatavalid), 32'd0);
    chk("idle_dropped", 32'(dropped), 32'd0);
    chk("idle_fast_busy", 32'(f_busy), 32'd0);

    // Write then read back with exact latency.
    do_write(25'd0, 16'h1234);
    do_read(25'd0, 16'h1234);
    @(negedge clk);
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_rdv", 32'(readdatavalid), 32'd1);
    chk("t1_data", 32'(readdata), 32'h1234);

    // Read edge during write occupancy is dropped.
    d0 = drop_cnt;
    write = 1'b1; writeaddress = 25'd16; writedata = 16'hBEEF;
    @(negedge clk);
    write = 1'b0;
    repeat (3) @(negedge clk);
    read = 1'b1; readaddress = 25'd16;
    @(negedge clk);
    chk("t2_dropped", 32'(dropped), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    read = 1'b0;
    repeat (4) @(negedge clk);
    do_read(25'd16, 16'hBEEF);
    repeat (2) @(negedge clk);
    chk("t2_drop_count", 32'(drop_cnt - d0), 32'd1);

    // Simultaneous edges: write wins, busy for 9 cycles.
    d0 = drop_cnt;
    read = 1'b1; readaddress = 25'd0;
    write = 1'b1; writeaddress = 25'd32; writedata = 16'h00AA;
    @(negedge clk);
    chk("t3_dropped", 32'(dropped), 32'd1);
    read = 1'b0; write = 1'b0;
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      bc += int'(busy);
      @(negedge clk);
    end
    chk("t3_busy_cycles", 32'(bc), 32'd9);
    chk("t3_drop_count", 32'(drop_cnt - d0), 32'd1);

    // Held level gives one read; address 37 truncates to word 2.
    r0 = rdv_cnt;
    begin
      exp_t e;
      read = 1'b1; readaddress = 25'd37;
      e.data = 16'h00AA; e.due = cyc + 1 + 3;
      sb.push_back(e);
    end
    repeat (20) @(negedge clk);
    read = 1'b0;
    chk("t4_rdv_count", 32'(rdv_cnt - r0), 32'd1);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Out-of-range write is discarded and must not alias word 0.
    do_write(25'd16384, 16'h5555);
    do_read(25'd16384, 16'h0000);
    do_read(25'd0, 16'h1234);
    repeat (2) @(negedge clk);

    // Reset one cycle after read acceptance.
    r0 = rdv_cnt;
    read = 1'b1; readaddress = 25'd16;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("t6_readdata", 32'(readdata), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rdv", 32'(readdatavalid), 32'd0);
    read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_no_rdv", 32'(rdv_cnt - r0), 32'd0);
    do_read(25'd16, 16'hBEEF);
    do_read(25'd0, 16'h1234);
    do_read(25'd32, 16'h00AA);
    repeat (2) @(negedge clk);
    chk("t6_sb_drained", 32'(sb.size()), 32'd0);

    // Minimum latencies with back-to-back alternating edges.
    for (int i = 0; i < 6; i++) begin
      fe[i] = 16'($urandom);
      f_read = 1'b0; f_write = 1'b1; f_waddr = 25'(i * 16); f_wdata = fe[i];
      @(negedge clk);
      f_write = 1'b0; f_read = 1'b1; f_raddr = 25'(i * 16);
      if (i > 0) begin
        chk("t7_rdv", 32'(f_rdv), 32'd1);
        chk("t7_data", 32'(f_rdata), 32'(fe[i-1]));
      end
      chk("t7_no_drop", 32'(f_dropped), 32'd0);
      @(negedge clk);
    end
    f_read = 1'b0;
    @(negedge clk);
    chk("t7_rdv_last", 32'(f_rdv), 32'd1);
    chk("t7_data_last", 32'(f_rdata), 32'(fe[5]));
    @(negedge clk);
    chk("t7_idle", 32'(f_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable memory-side responder for the single-word SDRAM read/write port used by the KNN core (`read`/`readaddress`/`readdata`, `write`/`writeaddress`/`writedata`). It stands in for the external SDRAM during simulation and FPGA bring-up. It reproduces the device's fixed read latency and long write occupancy, so the KNN master can be exercised unchanged. Storage is an internal word array. Addresses arrive as bit offsets, exactly as the master produces them.

## Interface
- `W`, 16, data word width in bits; power of two.
- `ADDR_W`, 25, address width; address is a bit offset into memory.
- `DEPTH`, 1024, number of W-bit words stored.
- `READ_LATENCY`, 3, cycles from read acceptance to data valid; ≥1.
- `WRITE_CYCLES`, 9, cycles the responder stays busy after write acceptance; ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `read`  in  1  read request; acted on at its rising edge.
- `readaddress`  in  ADDR_W  bit-offset address of the read word.
- `readdata`  out  W  returned word; holds until the next read completes.
- `readdatavalid`  out  1  one-cycle pulse when `readdata` updates.
- `write`  in  1  write request; acted on at its rising edge.
- `writeaddress`  in  ADDR_W  bit-offset address of the write word.
- `writedata`  in  W  word to store.
- `busy`  out  1  high while a request is in progress.
- `dropped`  out  1  one-cycle pulse when a request edge is ignored.

## Operation
- Request edge detection:
  - Registers `read_q` and `write_q` sample `read` and `write` every cycle.
  - A read edge is `read & ~read_q`; a write edge is `write & ~write_q`.
  - A level held high generates only one request.
- Word index is `address >> log2(W)`. The low log2(W) address bits are ignored, so misaligned addresses truncate.
- States: IDLE, READ_WAIT, WRITE_WAIT. A down-counter `cnt` is sized to max(READ_LATENCY, WRITE_CYCLES).
- IDLE:
  - Write edge: `writedata` is committed to mem[index] at this same edge. `cnt` loads WRITE_CYCLES-1, state → WRITE_WAIT.
  - Read edge with no write edge: `readaddress` is latched, `cnt` loads READ_LATENCY-1, state → READ_WAIT.
  - Read and write edges in the same cycle: the write wins, the read is ignored, and `dropped` pulses.
- READ_WAIT:
  - While `cnt` ≠ 0, decrement.
  - At `cnt` = 0: `readdata` ← mem[latched index], or 0 if index ≥ DEPTH. `readdatavalid` pulses, state → IDLE.
- WRITE_WAIT: decrement `cnt`; at 0, state → IDLE.
- A request edge arriving in READ_WAIT or WRITE_WAIT is ignored, with no queuing, and `dropped` pulses for one cycle.
- Out of range (index ≥ DEPTH): reads return 0 and writes are discarded. Both still occupy their full latency.
- Read-after-write to the same address returns the new data, because the write commits at acceptance.

## Timing
- Reset values: `readdata`=0, `readdatavalid`=0, `busy`=0, `dropped`=0, `read_q`=`write_q`=0, state IDLE, `cnt`=0.
- Memory contents are not cleared by reset. Benches write before reading.
- Read accepted at edge T: `busy` is high from T to T+READ_LATENCY. `readdata` updates and `readdatavalid` rises at edge T+READ_LATENCY.
- The earliest next acceptance is edge T+READ_LATENCY; it is seen only if a new rising edge of `read` or `write` appears there.
- Write accepted at edge T: memory is updated at T and `busy` is high for WRITE_CYCLES cycles. The earliest next acceptance is edge T+WRITE_CYCLES.
- `busy` is a registered output: high in every non-IDLE state.
- Reset mid-operation:
  - An in-flight read is aborted and `readdata` returns to 0.
  - A write already committed stays in memory.
  - Request edges that were pending before reset are lost. `read_q`/`write_q` clear, so a level still high at reset release counts as a new edge.

## Test plan
- Write then read: write 0x1234 to address 0, then pulse read at address 0. Required: `readdata`=0x1234 with `readdatavalid` exactly 3 cycles after read acceptance, and `busy` low at that edge.
- Write occupancy: write 0xBEEF to address 16 (word 1), then raise `read` 4 cycles later. Required: `dropped` pulses and no `readdatavalid`. A read edge issued 9 cycles after the write returns 0xBEEF.
- Collision: rising edges on `read` and `write` in the same cycle (write 0x00AA to address 32). Required: the write commits, `dropped` pulses once, and `busy` lasts 9 cycles.
- Held level / misalignment:
  - Hold `read` high for 20 cycles at address 37. Required: exactly one `readdatavalid`, returning word 2.
  - Write to address 16·1024. Required: the write is discarded, and a read there returns 0.
- Reset mid-read: assert `rst` 1 cycle after read acceptance. Required: all outputs 0 immediately (asynchronously), no `readdatavalid`, and previously written words intact after reset.
- Parameter sweep: READ_LATENCY=1, WRITE_CYCLES=1, back-to-back alternating write/read edges. Required: each read returns the preceding write's data one cycle after acceptance.
